// File: rtl/mvprod_chunk_sequencer_if.sv
// Byte-stream and MVProd-engine bundle for mvprod_chunk_sequencer.
// master = sequencer side, slave = the upstream/downstream/engine side.
// Bytes are two's-complement but are passed through untouched, so they are
// carried as plain 8-bit vectors.
interface mvprod_chunk_sequencer_if #(
   parameter int WorkingRegs = 4
);
   // upstream byte stream
   logic                        in_valid;
   logic [7:0]                  in_byte;
   logic                        in_ready;
   // downstream byte stream
   logic                        out_valid;
   logic [7:0]                  out_byte;
   logic                        out_ready;
   // engine side
   logic                        eng_in_data_ready;
   logic [WorkingRegs-1:0][7:0] eng_in_data;
   logic                        eng_req_chunk_in;
   logic                        eng_req_chunk_ptr_rst;
   logic                        eng_req_chunk_out;
   logic [7:0]                  eng_write_out_data;
   logic                        eng_out_vector_valid;

   modport master (
      input  in_valid, in_byte, out_ready,
      input  eng_req_chunk_in, eng_req_chunk_ptr_rst, eng_req_chunk_out,
      input  eng_write_out_data, eng_out_vector_valid,
      output in_ready, out_valid, out_byte, eng_in_data_ready, eng_in_data
   );

   modport slave (
      output in_valid, in_byte, out_ready,
      output eng_req_chunk_in, eng_req_chunk_ptr_rst, eng_req_chunk_out,
      output eng_write_out_data, eng_out_vector_valid,
      input  in_ready, out_valid, out_byte, eng_in_data_ready, eng_in_data
   );
endinterface

// File: rtl/mvprod_chunk_sequencer.sv
// mvprod_chunk_sequencer: buffers one input vector, serves it to an MVProd
// engine in WorkingRegs-wide chunks, collects the engine's result bytes and
// streams them out. One vector in flight: LOAD -> KICK -> RUN -> DRAIN.
// Optional: define MVPROD_SEQ_ERR_EN to build the sticky seq_err checker;
// otherwise seq_err is tied low.
module mvprod_chunk_sequencer #(
   parameter int InVecLength  = 16,
   parameter int OutVecLength = 8,
   parameter int WorkingRegs  = 4
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   mvprod_chunk_sequencer_if.master    bus,
   output logic                        busy,
   output logic                        seq_err
);
   localparam int NCH = InVecLength / WorkingRegs;
   localparam int LIW = $clog2(InVecLength) + 1;
   localparam int LAW = $clog2(InVecLength);
   localparam int OIW = $clog2(OutVecLength) + 1;
   localparam int OAW = $clog2(OutVecLength);
   localparam int PW  = $clog2(NCH) + 1;

   localparam logic [LIW-1:0] LD_LAST  = LIW'(InVecLength - 1);
   localparam logic [OIW-1:0] OUT_LAST = OIW'(OutVecLength - 1);
   localparam logic [OIW-1:0] OUT_FULL = OIW'(OutVecLength);
   localparam logic [PW-1:0]  PTR_LAST = PW'(NCH - 1);

   typedef enum logic [1:0] {S_LOAD, S_KICK, S_RUN, S_DRAIN} state_t;

   state_t         state, state_nxt;
   logic           ld_en;
   logic [LIW-1:0] ld_idx;
   logic [PW-1:0]  ptr;
   logic [OIW-1:0] out_idx;
   logic [OIW-1:0] rd_idx;
   logic [7:0]     ibuf [InVecLength];
   logic [7:0]     obuf [OutVecLength];

   logic in_acc, out_acc, out_cap;
   assign in_acc  = bus.in_valid & bus.in_ready;
   assign out_acc = bus.out_valid & bus.out_ready;
   assign out_cap = (state == S_RUN) && bus.eng_req_chunk_out && (out_idx != OUT_FULL);

   assign busy         = (state != S_LOAD) || (ld_idx != '0);
   assign bus.out_byte = obuf[rd_idx[OAW-1:0]];

   // state register
   always_ff @(posedge clk_in) begin
      if (rst_in) state <= S_LOAD;
      else        state <= state_nxt;
   end

   // next state and handshake outputs
   always_comb begin
      state_nxt             = state;
      bus.in_ready          = 1'b0;
      bus.out_valid         = 1'b0;
      bus.eng_in_data_ready = 1'b0;
      case (state)
         S_LOAD: begin
            // ld_en keeps in_ready low for the first cycle out of reset
            bus.in_ready = ld_en;
            if (bus.in_valid && ld_en && ld_idx == LD_LAST) state_nxt = S_KICK;
         end
         S_KICK: begin
            bus.eng_in_data_ready = 1'b1;
            state_nxt             = S_RUN;
         end
         S_RUN: begin
            // a byte arriving with vector_valid is still captured (out_cap)
            if (bus.eng_out_vector_valid || out_idx == OUT_FULL ||
                (out_cap && out_idx == OUT_LAST))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready && rd_idx == OUT_LAST) state_nxt = S_LOAD;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // counters and pointers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ld_en   <= 1'b0;
         ld_idx  <= '0;
         ptr     <= '0;
         out_idx <= '0;
         rd_idx  <= '0;
      end else begin
         ld_en <= 1'b1;
         case (state)
            S_LOAD: if (in_acc) ld_idx <= (ld_idx == LD_LAST) ? '0 : ld_idx + 1'b1;
            S_KICK: begin
               ptr     <= '0;
               out_idx <= '0;
               rd_idx  <= '0;
            end
            S_RUN: begin
               if (bus.eng_req_chunk_ptr_rst) ptr <= '0;
               else if (bus.eng_req_chunk_in) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
               if (out_cap) out_idx <= out_idx + 1'b1;
            end
            S_DRAIN: if (out_acc) rd_idx <= rd_idx + 1'b1;
            default: ;
         endcase
      end
   end

   // data buffers, no reset needed
   always_ff @(posedge clk_in) begin
      if (state == S_LOAD && in_acc) ibuf[ld_idx[LAW-1:0]] <= bus.in_byte;
      if (out_cap) obuf[out_idx[OAW-1:0]] <= bus.eng_write_out_data;
   end

   // chunk mux: byte k of the vector sits at chunk k/WR, lane k%WR
   always_comb begin
      bus.eng_in_data = '0;
      for (int c = 0; c < NCH; c++)
         if (ptr == PW'(c))
            for (int l = 0; l < WorkingRegs; l++)
               bus.eng_in_data[l] = ibuf[c*WorkingRegs + l];
   end

`ifdef MVPROD_SEQ_ERR_EN
   logic err_q, err_hit;
   assign err_hit =
      ((bus.eng_req_chunk_in | bus.eng_req_chunk_ptr_rst | bus.eng_req_chunk_out) && state != S_RUN) ||
      (bus.eng_req_chunk_out && out_idx == OUT_FULL) ||
      (bus.eng_out_vector_valid && out_idx != OUT_FULL);

   // sticky protocol error, cleared only by reset
   always_ff @(posedge clk_in) begin
      if (rst_in)       err_q <= 1'b0;
      else if (err_hit) err_q <= 1'b1;
   end
   assign seq_err = err_q;
`else
   assign seq_err = 1'b0;
`endif
endmodule
